vblank_update_scheduler: RTL and testbench

// Shares the single game-state update slot among N requesters (FSM, penguin physics, coin, barrier logic).

---
 rtl/vblank_update_scheduler_pkg.sv | 19 +
 rtl/vblank_update_scheduler_if.sv | 16 +
 rtl/vblank_update_scheduler_rr_arbiter.sv | 33 +++
 rtl/vblank_update_scheduler.sv | 147 ++++++++++++++
 tb/tb_vblank_update_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vblank_update_scheduler_pkg.sv
// Shared definitions for the vblank update scheduler: FSM state encoding,
// default requester count and the vertical-blanking test.
package vblank_update_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_GRANT
   } sched_state_t;

   localparam int N_REQ_DEFAULT = 4;

   // Blanking lies below the active area or above it (negative sy = front porch/sync)
   function automatic logic is_blank(input logic signed [15:0] sy,
                                     input logic signed [15:0] v_res);
      return sy[15] || (sy >= v_res);
   endfunction

endpackage

// File: rtl/vblank_update_scheduler_if.sv
// Request/grant handshake between the update requesters and the scheduler.
interface vblank_update_scheduler_if
   import vblank_update_scheduler_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT
);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] gnt;
   logic             busy;

   modport master (output req, output done, input gnt, input busy);
   modport slave  (input req, input done, output gnt, output busy);

endinterface

// File: rtl/vblank_update_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible bit strictly after the pointer.
module vblank_update_scheduler_rr_arbiter
   import vblank_update_scheduler_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic [N_REQ-1:0] elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] winner,
   output logic [IDX_W-1:0] winner_idx,
   output logic             valid
);

   logic [IDX_W-1:0] idx;

   // Scan N_REQ positions starting just past the last winner; the pointer itself is checked last
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      valid      = 1'b0;
      idx        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % N_REQ);
         if (!valid && elig[idx]) begin
            valid       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Hands the single game-state update slot to one requester at a time, each at
// most once per frame and only while the display is in vertical blanking.
module vblank_update_scheduler
   import vblank_update_scheduler_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEFAULT,
   parameter int V_RES   = 720,
   parameter int MAX_GNT = 1024,
   parameter int CNT_W   = 16
)(
   input  logic                     i_pix_clk,
   input  logic                     i_rst_n,
   input  logic signed [15:0]       i_sy,
   input  logic                     i_clr_status,
   vblank_update_scheduler_if.slave upd,
   output logic                     o_window,
   output logic [CNT_W-1:0]         o_frame_cnt,
   output logic [N_REQ-1:0]         o_timeout,
   output logic [N_REQ-1:0]         o_missed
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BW    = $clog2(MAX_GNT + 1);
   localparam logic signed [15:0] V_RES_S = 16'(V_RES);
   localparam logic [BW-1:0]      BUDGET  = BW'(MAX_GNT);

   sched_state_t     state;
   logic [N_REQ-1:0] gnt_q;
   logic             busy_q;
   logic [N_REQ-1:0] served;
   logic [IDX_W-1:0] ptr;
   logic [BW-1:0]    budget_cnt;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] arb_onehot;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;
   logic             blank_now;
   logic             open_evt;
   logic             close_evt;
   logic [N_REQ-1:0] done_hit_mask;
   logic             done_hit;
   logic             expired;
   logic [N_REQ-1:0] served_eff;
   logic [N_REQ-1:0] timeout_set;
   logic [N_REQ-1:0] missed_set;

   vblank_update_scheduler_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .elig       (elig),
      .ptr        (ptr),
      .winner     (arb_onehot),
      .winner_idx (arb_idx),
      .valid      (arb_valid)
   );

   // Window edges are taken against the registered flag, so they coincide with o_window changing.
   // A done arriving in the closing cycle still counts as served.
   always_comb begin
      blank_now     = is_blank(i_sy, V_RES_S);
      open_evt      = blank_now & ~o_window;
      close_evt     = ~blank_now & o_window;
      elig          = upd.req & ~served;
      done_hit_mask = (state == ST_GRANT) ? (upd.done & gnt_q) : '0;
      done_hit      = |done_hit_mask;
      expired       = (state == ST_GRANT) && !done_hit && (budget_cnt == BUDGET);
      served_eff    = served | done_hit_mask;
      missed_set    = close_evt ? (upd.req & ~served_eff) : '0;
      timeout_set   = (expired && !close_evt) ? gnt_q : '0;
   end

   // Window open/close override whatever the arbitration FSM is doing that cycle
   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         gnt_q       <= '0;
         busy_q      <= 1'b0;
         served      <= '0;
         ptr         <= IDX_W'(N_REQ - 1);
         budget_cnt  <= '0;
         o_window    <= 1'b0;
         o_frame_cnt <= '0;
         o_timeout   <= '0;
         o_missed    <= '0;
      end else begin
         o_window <= blank_now;

         if (i_clr_status) begin
            o_timeout <= '0;
            o_missed  <= '0;
         end else begin
            o_timeout <= o_timeout | timeout_set;
            o_missed  <= o_missed | missed_set;
         end

         if (open_evt) begin
            o_frame_cnt <= o_frame_cnt + 1'b1;
            served      <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            state       <= ST_ARB;
         end else if (close_evt) begin
            served <= served_eff;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
               end
               ST_ARB: begin
                  if (arb_valid) begin
                     gnt_q      <= arb_onehot;
                     busy_q     <= 1'b1;
                     ptr        <= arb_idx;
                     budget_cnt <= BW'(1);
                     state      <= ST_GRANT;
                  end
               end
               ST_GRANT: begin
                  if (done_hit || expired) begin
                     gnt_q  <= '0;
                     busy_q <= 1'b0;
                     served <= served | gnt_q;
                     state  <= ST_ARB;
                  end else begin
                     budget_cnt <= budget_cnt + 1'b1;
                  end
               end
               default: begin
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign upd.gnt  = gnt_q;
   assign upd.busy = busy_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Scoreboard bench for vblank_update_scheduler: expected grants are queued by the
// stimulus thread and popped by a monitor whenever a new grant appears.
module tb_vblank_update_scheduler;

   localparam int N       = 4;
   localparam int V_RES   = 720;
   localparam int MAX_GNT = 16;
   localparam int CNT_W   = 8;
   localparam logic signed [15:0] BLANK  = 16'sd720;
   localparam logic signed [15:0] ACTIVE = 16'sd100;

   typedef struct {
      logic [N-1:0] gnt;
      int           len;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic signed [15:0]  sy_drv;
   logic                clr;
   logic                window;
   logic [CNT_W-1:0]    frame_cnt;
   logic [N-1:0]        timeout;
   logic [N-1:0]        missed;

   int   errors;
   int   checks;
   exp_t exp_q[$];
   logic done_en [N];
   int   done_delay [N];

   vblank_update_scheduler_if #(.N_REQ(N)) upd ();

   vblank_update_scheduler #(
      .N_REQ   (N),
      .V_RES   (V_RES),
      .MAX_GNT (MAX_GNT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_pix_clk    (clk),
      .i_rst_n      (rst_n),
      .i_sy         (sy_drv),
      .i_clr_status (clr),
      .upd          (upd),
      .o_window     (window),
      .o_frame_cnt  (frame_cnt),
      .o_timeout    (timeout),
      .o_missed     (missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic signed [15:0] sy, input logic [N-1:0] req, input int n);
      sy_drv  = sy;
      upd.req = req;
      repeat (n) @(negedge clk);
   endtask

   task automatic pushGrant(input logic [N-1:0] g, input int len);
      exp_t e;
      e.gnt = g;
      e.len = len;
      exp_q.push_back(e);
   endtask

   // Requester model: pulses done on the cycle its grant has been held done_delay cycles
   initial begin : responder
      logic [N-1:0] prev_g;
      int           run_len;
      prev_g   = '0;
      run_len  = 0;
      upd.done = '0;
      forever begin
         @(negedge clk);
         if (upd.gnt == '0)          run_len = 0;
         else if (upd.gnt == prev_g) run_len++;
         else                        run_len = 1;
         upd.done = '0;
         for (int i = 0; i < N; i++)
            if (upd.gnt[i] && done_en[i] && run_len == done_delay[i])
               upd.done[i] = 1'b1;
         prev_g = upd.gnt;
      end
   end

   // Monitor: each new grant pops one expectation; grant length is checked when it ends
   initial begin : monitor
      logic [N-1:0] prev_g;
      int           run_len;
      exp_t         cur;
      prev_g  = '0;
      run_len = 0;
      cur.gnt = '0;
      cur.len = -1;
      forever begin
         @(negedge clk);
         if (upd.gnt != prev_g) begin
            if (prev_g != '0) begin
               if (cur.len >= 0) checkOutput("grant_len", run_len, cur.len);
               if (upd.gnt == '0) checkOutput("busy_low", int'(upd.busy), 0);
            end
            if (upd.gnt != '0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_grant: got %b, expected none", upd.gnt);
                  cur.gnt = upd.gnt;
                  cur.len = -1;
               end else begin
                  cur = exp_q.pop_front();
                  checkOutput("grant_vec", int'(upd.gnt), int'(cur.gnt));
                  checkOutput("busy_high", int'(upd.busy), 1);
               end
               run_len = 1;
            end else begin
               run_len = 0;
            end
         end else if (upd.gnt != '0) begin
            run_len++;
         end
         prev_g = upd.gnt;
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      clr     = 1'b0;
      sy_drv  = ACTIVE;
      upd.req = '0;
      for (int i = 0; i < N; i++) begin
         done_en[i]    = 1'b0;
         done_delay[i] = 10;
      end

      repeat (2) @(negedge clk);
      checkOutput("rst_gnt",     int'(upd.gnt), 0);
      checkOutput("rst_busy",    int'(upd.busy), 0);
      checkOutput("rst_window",  int'(window), 0);
      checkOutput("rst_frame",   int'(frame_cnt), 0);
      checkOutput("rst_timeout", int'(timeout), 0);
      checkOutput("rst_missed",  int'(missed), 0);
      rst_n = 1'b1;

      // Reset in the middle of a grant to req1
      pushGrant(4'b0010, -1);
      applyStimulus(BLANK, 4'b0010, 5);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_gnt", int'(upd.gnt), 0);
      sy_drv  = ACTIVE;
      upd.req = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst2_frame",  int'(frame_cnt), 0);
      checkOutput("rst2_window", int'(window), 0);
      rst_n = 1'b1;

      // All four requesting: pointer back at N-1 so order is 0,1,2,3
      for (int i = 0; i < N; i++) begin
         done_en[i]    = 1'b1;
         done_delay[i] = 10;
      end
      pushGrant(4'b0001, 10);
      pushGrant(4'b0010, 10);
      pushGrant(4'b0100, 10);
      pushGrant(4'b1000, 10);
      applyStimulus(BLANK, 4'b1111, 60);
      applyStimulus(ACTIVE, 4'b1111, 2);
      checkOutput("rr_frame",   int'(frame_cnt), 1);
      checkOutput("rr_missed",  int'(missed), 0);
      checkOutput("rr_timeout", int'(timeout), 0);
      applyStimulus(ACTIVE, 4'b0000, 1);

      // req1 never finishes: revoked after MAX_GNT, then req2 served
      done_en[1]    = 1'b0;
      done_delay[2] = 4;
      pushGrant(4'b0010, 16);
      pushGrant(4'b0100, 4);
      applyStimulus(BLANK, 4'b0110, 30);
      applyStimulus(ACTIVE, 4'b0000, 2);
      checkOutput("to_timeout", int'(timeout), 4'b0010);
      checkOutput("to_missed",  int'(missed), 0);
      checkOutput("to_frame",   int'(frame_cnt), 2);
      clr = 1'b1;
      applyStimulus(ACTIVE, 4'b0000, 1);
      clr = 1'b0;
      checkOutput("to_cleared", int'(timeout), 0);

      // Request raised in active video waits for the window
      done_delay[2] = 5;
      applyStimulus(ACTIVE, 4'b0100, 5);
      checkOutput("active_no_gnt", int'(upd.gnt), 0);
      pushGrant(4'b0100, 5);
      applyStimulus(BLANK, 4'b0100, 1);
      checkOutput("open_window", int'(window), 1);
      checkOutput("open_no_gnt", int'(upd.gnt), 0);
      applyStimulus(BLANK, 4'b0100, 1);
      checkOutput("open_gnt", int'(upd.gnt), 4'b0100);
      applyStimulus(BLANK, 4'b0100, 10);
      applyStimulus(ACTIVE, 4'b0000, 2);
      checkOutput("open_missed", int'(missed), 0);
      checkOutput("open_frame",  int'(frame_cnt), 3);

      // req3 still granted when the window closes
      done_en[3] = 1'b0;
      pushGrant(4'b1000, 5);
      applyStimulus(BLANK, 4'b1000, 6);
      applyStimulus(ACTIVE, 4'b1000, 1);
      checkOutput("close_gnt",    int'(upd.gnt), 0);
      checkOutput("close_missed", int'(missed), 4'b1000);
      clr = 1'b1;
      applyStimulus(ACTIVE, 4'b0000, 1);
      clr = 1'b0;
      checkOutput("missed_cleared", int'(missed), 0);

      // Clear in the same cycle as a missed set leaves the flag low
      pushGrant(4'b1000, 5);
      applyStimulus(BLANK, 4'b1000, 6);
      clr = 1'b1;
      applyStimulus(ACTIVE, 4'b1000, 1);
      clr = 1'b0;
      checkOutput("clr_priority", int'(missed), 0);
      applyStimulus(ACTIVE, 4'b0000, 1);
      checkOutput("clr_frame", int'(frame_cnt), 5);

      // Done lands on the budget-expiry cycle: no timeout
      done_en[0]    = 1'b1;
      done_delay[0] = MAX_GNT;
      pushGrant(4'b0001, 16);
      applyStimulus(BLANK, 4'b0001, 25);
      applyStimulus(ACTIVE, 4'b0000, 2);
      checkOutput("tie_timeout", int'(timeout), 0);
      checkOutput("tie_missed",  int'(missed), 0);
      checkOutput("tie_frame",   int'(frame_cnt), 6);

      // Frame counter wrap
      for (int i = 0; i < 249; i++) begin
         applyStimulus(BLANK, 4'b0000, 1);
         applyStimulus(ACTIVE, 4'b0000, 1);
      end
      checkOutput("frame_max", int'(frame_cnt), 255);
      applyStimulus(BLANK, 4'b0000, 1);
      applyStimulus(ACTIVE, 4'b0000, 1);
      checkOutput("frame_wrap", int'(frame_cnt), 0);

      repeat (2) @(negedge clk);
      checkOutput("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
